// File: rtl/burst_line_ctrl_pkg.sv
// Shared types and constants for the cache-line to BurstRAM adapter.
package burst_line_ctrl_pkg;

    localparam int unsigned WORD_W = 64;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_RESP
    } state_t;

endpackage

// File: rtl/burst_line_ctrl.sv
// Converts one line-sized read/write request into a single BurstRAM burst,
// streaming the burst words to or from one wide line register.
module burst_line_ctrl
    import burst_line_ctrl_pkg::*;
#(
    parameter int unsigned BURST_COUNT    = 4,
    parameter int unsigned DEPTH_BITWIDTH = 4,
    localparam int unsigned OFF_W          = $clog2(BURST_COUNT),
    localparam int unsigned LINE_BITS      = WORD_W * BURST_COUNT,
    localparam int unsigned LINE_ADDR_BITS = DEPTH_BITWIDTH - OFF_W,
    localparam int unsigned MASK_BITS      = LINE_BITS / 8,
    localparam int unsigned BYTES_W        = WORD_W / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [LINE_ADDR_BITS-1:0] req_line,
    input  logic [LINE_BITS-1:0]      req_wdata,
    input  logic [MASK_BITS-1:0]      req_wmask,
    output logic                      rsp_valid,
    output logic [LINE_BITS-1:0]      rsp_rdata,
    output logic                      cmd,
    output logic                      cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] addr,
    output logic [WORD_W-1:0]         wr_data,
    output logic [BYTES_W-1:0]        data_mask,
    input  logic [WORD_W-1:0]         rd_data,
    input  logic                      rd_data_valid,
    input  logic                      busy
);

    localparam int unsigned CNT_W = OFF_W + 1;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LINE_BITS-1:0]      line_q, line_d;
    logic [MASK_BITS-1:0]      mask_q, mask_d;
    logic [LINE_BITS-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      cmd_q, cmd_d;
    logic                      cmd_en_q, cmd_en_d;
    logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]         wr_data_q, wr_data_d;
    logic [BYTES_W-1:0]        data_mask_q, data_mask_d;

    logic                      accept_c;
    logic [OFF_W-1:0]          idx_c;

    // Ready depends on live busy so a dropping busy is honoured the same cycle.
    assign req_ready = (state_q == ST_IDLE) && !busy && !rst;
    assign accept_c  = req_valid && req_ready;
    assign idx_c     = cnt_q[OFF_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        mask_d      = mask_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        cmd_d       = cmd_q;
        cmd_en_d    = 1'b0;
        addr_d      = addr_q;
        wr_data_d   = '0;
        data_mask_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    addr_d   = {req_line, OFF_W'(0)};
                    cmd_en_d = 1'b1;
                    cnt_d    = '0;
                    if (req_write) begin
                        cmd_d       = CMD_WRITE;
                        line_d      = req_wdata;
                        mask_d      = req_wmask;
                        wr_data_d   = req_wdata[WORD_W-1:0];
                        data_mask_d = req_wmask[BYTES_W-1:0];
                        cnt_d       = CNT_W'(1);
                        state_d     = ST_WR_BURST;
                    end else begin
                        cmd_d   = CMD_READ;
                        state_d = ST_RD_WAIT;
                    end
                end
            end

            ST_RD_WAIT, ST_RD_BURST: begin
                if (rd_data_valid) begin
                    line_d[idx_c*WORD_W +: WORD_W] = rd_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_RD_BURST;
                    if (cnt_q == CNT_W'(BURST_COUNT - 1)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = line_d;
                    end
                end
            end

            // cnt_q already points at the word to present in the next cycle.
            ST_WR_BURST: begin
                if (cnt_q == CNT_W'(BURST_COUNT)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    wr_data_d   = line_q[idx_c*WORD_W +: WORD_W];
                    data_mask_d = mask_q[idx_c*BYTES_W +: BYTES_W];
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            mask_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            cmd_q       <= 1'b0;
            cmd_en_q    <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            data_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            mask_q      <= mask_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_q       <= cmd_d;
            cmd_en_q    <= cmd_en_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            data_mask_q <= data_mask_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cmd       = cmd_q;
    assign cmd_en    = cmd_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign data_mask = data_mask_q;

endmodule

// File: tb/tb_burst_line_ctrl.sv
// Scoreboard bench for burst_line_ctrl: a behavioural BurstRAM, a line-level
// reference memory, and a monitor that checks commands, write words and responses.
module tb_burst_line_ctrl;
    import burst_line_ctrl_pkg::*;

    localparam int unsigned BC  = 4;
    localparam int unsigned DB  = 4;
    localparam int unsigned OFF = $clog2(BC);
    localparam int unsigned LB  = 64 * BC;
    localparam int unsigned LAB = DB - OFF;
    localparam int unsigned MB  = LB / 8;
    localparam int unsigned NW  = 1 << DB;

    localparam logic [LB-1:0] LINE0 =
        256'h7D4E9F2C1B6A3D8F_A1C3F7E2D5B8A9C4_9D8E2F17AB4C3E6F_3F5A2E14B7C6A980;
    localparam logic [LB-1:0] LINE1 =
        256'hD4E7F2C5B8A3D6E9_F8E9D2C3B4A5F6E7_E1A7D0B5C8F3E6A9_6C4B9A8D2F5E3C7A;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [LAB-1:0] req_line = '0;
    logic [LB-1:0]  req_wdata = '0;
    logic [MB-1:0]  req_wmask = '0;
    logic           rsp_valid;
    logic [LB-1:0]  rsp_rdata;
    logic           cmd;
    logic           cmd_en;
    logic [DB-1:0]  addr;
    logic [63:0]    wr_data;
    logic [7:0]     data_mask;
    logic [63:0]    rd_data = '0;
    logic           rd_data_valid = 1'b0;
    logic           busy = 1'b0;

    burst_line_ctrl #(.BURST_COUNT(BC), .DEPTH_BITWIDTH(DB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_line(req_line), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
        .wr_data(wr_data), .data_mask(data_mask),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [DB-1:0] addr;
        int            cyc;
        logic [LB-1:0] wd;
        logic [MB-1:0] wm;
    } cmd_exp_t;

    typedef struct {
        logic          w;
        logic [LB-1:0] rd;
        int            cyc;
    } rsp_exp_t;

    cmd_exp_t    cmd_q[$];
    rsp_exp_t    rsp_q[$];
    logic [63:0] ram_mem [NW];
    logic [63:0] ref_mem [NW];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit gap_en    = 1'b0;
    bit junk_en   = 1'b0;
    bit busy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: a line is BC words of a flat word memory; writes merge bytewise.
    function automatic void push_exp(input logic w, input logic [LAB-1:0] ln,
                                     input logic [LB-1:0] wd, input logic [MB-1:0] wm);
        cmd_exp_t      ce;
        rsp_exp_t      re;
        logic [LB-1:0] cur;
        for (int i = 0; i < int'(BC); i++) cur[64*i +: 64] = ref_mem[int'(ln)*int'(BC) + i];
        re.rd = cur;
        if (w) begin
            for (int b = 0; b < int'(MB); b++) if (!wm[b]) cur[8*b +: 8] = wd[8*b +: 8];
            for (int i = 0; i < int'(BC); i++) ref_mem[int'(ln)*int'(BC) + i] = cur[64*i +: 64];
        end
        ce.w = w; ce.addr = DB'(int'(ln) * int'(BC)); ce.cyc = cyc + 1; ce.wd = wd; ce.wm = wm;
        re.w = w; re.cyc = 0;
        cmd_q.push_back(ce);
        rsp_q.push_back(re);
    endfunction

    // Behavioural BurstRAM: fixed read latency, optional gaps, stray valids during writes.
    int          rd_idx = 0;
    int          rd_delay = 0;
    int          wr_idx = 0;
    bit          rd_active = 1'b0;
    bit          wr_active = 1'b0;
    bit          wrote;
    logic [DB-1:0] rd_base, wr_base;

    initial begin
        forever begin
            @(negedge clk);
            wrote = 1'b0;
            if (rst) begin
                rd_active = 1'b0; wr_active = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
            end else begin
                if (cmd_en && cmd == CMD_WRITE) begin wr_active = 1'b1; wr_base = addr; wr_idx = 0; end
                if (wr_active) begin
                    for (int b = 0; b < 8; b++)
                        if (!data_mask[b]) ram_mem[int'(wr_base) + wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                    wr_idx++;
                    wrote = 1'b1;
                    if (wr_idx == int'(BC)) wr_active = 1'b0;
                end
                if (cmd_en && cmd == CMD_READ) begin
                    rd_active = 1'b1; rd_base = addr; rd_idx = 0; rd_delay = 4;
                end
                rd_data_valid = 1'b0;
                rd_data = {$urandom, $urandom};
                if (rd_active) begin
                    if (rd_delay > 0) rd_delay--;
                    else if (gap_en && $urandom_range(0, 3) == 0) rd_data_valid = 1'b0;
                    else begin
                        rd_data_valid = 1'b1;
                        rd_data = ram_mem[int'(rd_base) + rd_idx];
                        rd_idx++;
                        if (rd_idx == int'(BC)) rd_active = 1'b0;
                    end
                end else if (wrote && junk_en && $urandom_range(0, 1) == 1) begin
                    rd_data_valid = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a command or response.
    cmd_exp_t ce_m;
    cmd_exp_t wr_cur;
    rsp_exp_t re_m;
    int       wr_win = 0;
    int       k;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_win = 0;
            end else begin
                if (cmd_en) begin
                    if (cmd_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL cmd_en: got unexpected strobe addr %h expected none (cycle %0d)", addr, cyc);
                    end else begin
                        ce_m = cmd_q.pop_front();
                        chk("cmd", LB'(cmd), LB'(ce_m.w));
                        chk("addr", LB'(addr), LB'(ce_m.addr));
                        chk("cmd_cycle", LB'(cyc), LB'(ce_m.cyc));
                        if (ce_m.w) begin
                            wr_win = int'(BC);
                            wr_cur = ce_m;
                            if (rsp_q.size() > 0) rsp_q[0].cyc = cyc + int'(BC);
                        end
                    end
                end
                if (wr_win > 0) begin
                    k = int'(BC) - wr_win;
                    chk("wr_data", LB'(wr_data), LB'(wr_cur.wd[64*k +: 64]));
                    chk("data_mask", LB'(data_mask), LB'(wr_cur.wm[8*k +: 8]));
                    wr_win--;
                end else begin
                    chk("wr_idle", LB'({data_mask, wr_data}), '0);
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rsp_valid: got unexpected pulse expected none (cycle %0d)", cyc);
                    end else begin
                        re_m = rsp_q.pop_front();
                        if (re_m.w) chk("wr_rsp_cycle", LB'(cyc), LB'(re_m.cyc));
                        else        chk("rsp_rdata", rsp_rdata, re_m.rd);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic [LAB-1:0] ln,
                          input logic [LB-1:0] wd, input logic [MB-1:0] wm);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 400) begin
            @(negedge clk);
            busy = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            req_valid = 1'b1; req_write = w; req_line = ln; req_wdata = wd; req_wmask = wm;
            #1;
            if (req_ready) begin
                acc = 1'b1;
                push_exp(w, ln, wd, wm);
            end
            n++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL req_accept: got no req_ready in %0d cycles expected acceptance", n);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            busy = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            #1;
            n++;
        end
        if (n >= 400) begin
            n_checks++; n_fail++;
            $display("FAIL completion: got %0d pending responses expected 0", rsp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_cmd_en"}, LB'(cmd_en), '0);
        chk({tag, "_cmd"}, LB'(cmd), '0);
        chk({tag, "_addr"}, LB'(addr), '0);
        chk({tag, "_wr_data"}, LB'(wr_data), '0);
        chk({tag, "_data_mask"}, LB'(data_mask), '0);
        chk({tag, "_rsp_valid"}, LB'(rsp_valid), '0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, '0);
        chk({tag, "_req_ready"}, LB'(req_ready), '0);
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        for (int j = 0; j < int'(LB / 32); j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [LB-1:0] l0, l1, wd;
        logic [MB-1:0] wm;
        logic [LAB-1:0] ln;
        logic           w;
        int             n;

        l0 = LINE0;
        l1 = LINE1;
        for (int i = 0; i < int'(NW); i++) ram_mem[i] = {$urandom, $urandom};
        for (int i = 0; i < int'(BC); i++) begin
            ram_mem[i]      = l0[64*i +: 64];
            ram_mem[BC + i] = l1[64*i +: 64];
        end
        for (int i = 0; i < int'(NW); i++) ref_mem[i] = ram_mem[i];

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        busy = 1'b0;
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        do_req(1'b0, LAB'(0), '0, '0);
        wait_done();
        do_req(1'b0, LAB'(1), '0, '0);
        wait_done();

        junk_en = 1'b1;
        wd = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        do_req(1'b1, LAB'(2), wd, '0);
        wait_done();
        do_req(1'b0, LAB'(2), '0, '0);
        wait_done();

        wd = {LB{1'b1}};
        wd = wd & {32{8'hAA}};
        do_req(1'b1, LAB'(2), wd, MB'(1));
        wait_done();
        do_req(1'b0, LAB'(2), '0, '0);
        wait_done();

        // busy held with a pending request: no acceptance until it drops
        @(negedge clk);
        busy = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_line = LAB'(1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("req_ready_busy", LB'(req_ready), '0);
            @(negedge clk);
        end
        busy = 1'b0;
        #1;
        chk("req_ready_free", LB'(req_ready), LB'(1));
        if (req_ready) push_exp(1'b0, LAB'(1), '0, '0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done();

        // reset after the second read word has been captured
        do_req(1'b0, LAB'(0), '0, '0);
        n = 0;
        while (rd_idx < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL mid_burst: got %0d read words expected 2", rd_idx);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        cmd_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        do_req(1'b0, LAB'(0), '0, '0);
        wait_done();

        gap_en = 1'b1;
        busy_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            ln = LAB'($urandom_range(0, (1 << LAB) - 1));
            w  = 1'($urandom_range(0, 1));
            wd = rand_line();
            case ($urandom_range(0, 2))
                0:       wm = '0;
                1:       wm = MB'($urandom);
                default: wm = MB'(1) << $urandom_range(0, MB - 1);
            endcase
            do_req(w, ln, wd, wm);
        end
        wait_done();
        busy_rand = 1'b0;
        busy = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test expected completion before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/burst_line_ctrl.md
Name: burst_line_ctrl

Overview:
Cache-line adapter that sits directly upstream of BurstRAM. It turns one line-sized read or write request from the cache side into a single BurstRAM burst command. It also streams the BURST_COUNT 64-bit words of that burst to or from one wide line register. Only one transaction is in flight at a time, and each transaction completes with a one-cycle response pulse.

Parameters:
BURST_COUNT, 4, 64-bit words per burst/line (power of two)
DEPTH_BITWIDTH, 4, BurstRAM word-address width
LINE_BITS, 64*BURST_COUNT, derived line width
LINE_ADDR_BITS, DEPTH_BITWIDTH-log2(BURST_COUNT), derived line-address width

Ports:
clk  in  1  clock; everything on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  line request present
req_ready  out  1  controller accepts request this cycle
req_write  in  1  1=write line, 0=read line
req_line  in  LINE_ADDR_BITS  line address
req_wdata  in  LINE_BITS  write line; word i at bits [64i+63:64i]
req_wmask  in  LINE_BITS/8  byte mask, 1=byte NOT written
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  LINE_BITS  read line; valid only while rsp_valid on a read
cmd  out  1  BurstRAM command, 0=read, 1=write
cmd_en  out  1  BurstRAM command strobe
addr  out  DEPTH_BITWIDTH  BurstRAM word address = {req_line, zeros}
wr_data  out  64  BurstRAM write word
data_mask  out  8  BurstRAM byte mask, 1=byte disabled
rd_data  in  64  BurstRAM read word
rd_data_valid  in  1  BurstRAM read word valid
busy  in  1  BurstRAM cannot take a command

Behaviour:
- Reset values: all outputs are registered and reset to 0. State goes to IDLE and the word counter goes to 0. rsp_rdata is cleared to 0.
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, RESP.
- req_ready = (state==IDLE) && !busy. A request is accepted when req_valid && req_ready.
- On an accepted read:
  - Next cycle: cmd_en=1, cmd=0, addr={req_line, 0}.
  - The FSM goes to RD_WAIT. cmd_en is high for exactly one cycle.
- RD_WAIT and RD_BURST:
  - Each cycle with rd_data_valid=1, rd_data is captured into line word[cnt] and cnt is incremented.
  - The first captured word moves the FSM RD_WAIT -> RD_BURST.
  - After word BURST_COUNT-1 is captured, the FSM goes to RESP.
  - rd_data_valid gaps inside a burst are tolerated (no word is captured on a gap), but they are not expected.
- On an accepted write:
  - req_wdata and req_wmask are latched.
  - Next cycle: cmd_en=1, cmd=1, addr={req_line, 0}, wr_data=word0, data_mask=mask0.
  - The following BURST_COUNT-1 cycles drive word1..word(BURST_COUNT-1) with cmd_en=0.
  - Then the FSM goes to RESP.
- Outside write-burst cycles, wr_data and data_mask are 0.
- RESP: rsp_valid=1 for exactly one cycle.
  - On a read, rsp_rdata holds the assembled line and keeps it until the next read completes.
  - The FSM then returns to IDLE.
- Throughput: back-to-back requests are accepted earliest in the cycle after rsp_valid.
- busy high in IDLE holds req_ready low. busy is ignored once a command has been issued.
- rd_data_valid while in IDLE or WR_BURST is ignored and has no state change.
- req_valid while not ready is ignored; no request is queued.
- Address wrap: the line address maps directly to RAM words; there is no crossing between lines.
- Reset mid-burst aborts immediately. Outputs return to 0 and no rsp_valid is issued.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - the RAM command encodings CMD_READ=0 and CMD_WRITE=1;
  - the 64-bit word width constant.
- No sub-module. Line assembly and disassembly are indexed slices of one register.

Test Plan:
- Read line 0, BurstRAM preloaded as in sim_5 (CYCLES_BEFORE_DATA_READY=4) -> one cmd_en pulse with addr=0, then rsp_valid once with rsp_rdata=7D4E9F2C1B6A3D8F_A1C3F7E2D5B8A9C4_9D8E2F17AB4C3E6F_3F5A2E14B7C6A980.
- Read line 1 -> addr=4, rsp_rdata=D4E7F2C5B8A3D6E9_F8E9D2C3B4A5F6E7_E1A7D0B5C8F3E6A9_6C4B9A8D2F5E3C7A.
- Write line 2 with words 0x1111..., 0x2222..., 0x3333..., 0x4444... and mask 0 -> cmd_en with cmd=1 and addr=8, then 4 consecutive wr_data words in order, then rsp_valid. A following read of line 2 returns the same words.
- Write line 2 with mask bit 0 set for word0, data 0xAA..AA -> the read-back has word0 byte0 unchanged and all other bytes equal to 0xAA.
- Hold busy=1 with req_valid=1 for 3 cycles -> req_ready=0 and no cmd_en; after busy drops, the command issues on the next cycle.
- Assert rst after the second read word -> outputs are 0 next, no rsp_valid; a subsequent read of line 0 completes correctly.
